fp32_cmp_unit: RTL and testbench

FP32_CMP_UNIT -- requirements
Module: fp32_cmp_unit

---
 rtl/fp32_cmp_unit.sv | 95 +++++++++
 tb/tb_fp32_cmp_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fp32_cmp_unit.sv
// fp32_cmp_unit: FP32 predicate compare and max/min with optional int-to-FP32 operand conversion, 1-cycle latency.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid              operands/controls valid this cycle
//   int_mode              1 = in_a/in_b are signed integers converted to FP32 first
//   is_max                1 = max, 0 = min on the value path
//   is_op                 predicate: 0 EQ, 1 LT, 2 LE, 3 GT, 4 GE, 5-7 reserved (result 0)
//   in_a, in_b            operands
//   fp32_a, fp32_b        combinational FP32 form of the operands
//   result_fp32_valid/result_fp32   registered max/min value
//   result_valid/result/nan_err     registered predicate outcome and NaN flag
module fp32_cmp_unit #(
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        int_mode,
    input  logic        is_max,
    input  logic [2:0]  is_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] fp32_a,
    output logic [31:0] fp32_b,
    output logic        result_fp32_valid,
    output logic [31:0] result_fp32,
    output logic        result_valid,
    output logic        result,
    output logic        nan_err
);
    function automatic logic [31:0] int2fp(input logic [31:0] x);
        logic [31:0] mag;
        logic [31:0] norm;
        logic [4:0]  p;
        logic        rnd;
        mag = x[31] ? -x : x;
        p = 5'd0;
        for (int i = 0; i < 32; i++)
            if (mag[i]) p = i[4:0];
        norm = mag << (5'd31 - p);
        rnd = norm[7] && (|norm[6:0] || norm[8]);
        // exponent is built one low so the normalized leading one carries into it;
        // a rounding carry out of the mantissa likewise bumps the exponent
        return (mag == 32'd0) ? 32'd0 :
            {x[31], 8'd126 + {3'd0, p}, 23'd0} + {8'd0, norm[31:8]} + {31'd0, rnd};
    endfunction

    logic        w_nan_a, w_nan_b, w_nan, w_zero, w_eq, w_lt, w_pred, w_take_b;
    logic [31:0] w_key_a, w_key_b, w_pick;

    assign fp32_a  = int_mode ? int2fp(in_a) : in_a;
    assign fp32_b  = int_mode ? int2fp(in_b) : in_b;
    assign w_nan_a = &fp32_a[30:23] && |fp32_a[22:0];
    assign w_nan_b = &fp32_b[30:23] && |fp32_b[22:0];
    assign w_nan   = w_nan_a || w_nan_b;
    assign w_zero  = ~|fp32_a[30:0] && ~|fp32_b[30:0];
    assign w_eq    = (fp32_a == fp32_b) || w_zero;
    // sign-magnitude to monotonic unsigned key; the zero pair is handled by w_eq
    assign w_key_a = fp32_a[31] ? ~fp32_a : {1'b1, fp32_a[30:0]};
    assign w_key_b = fp32_b[31] ? ~fp32_b : {1'b1, fp32_b[30:0]};
    assign w_lt    = !w_eq && (w_key_a < w_key_b);

    always_comb begin
        w_pred   = w_nan        ? 1'b0 :
                   is_op == 3'd0 ? w_eq :
                   is_op == 3'd1 ? w_lt :
                   is_op == 3'd2 ? (w_lt || w_eq) :
                   is_op == 3'd3 ? !(w_lt || w_eq) :
                   is_op == 3'd4 ? !w_lt : 1'b0;
        w_take_b = is_max ? w_lt : (!w_lt && !w_eq);
        w_pick   = (w_nan_a && w_nan_b) ? CANON_NAN :
                   w_nan_a ? fp32_b :
                   w_nan_b ? fp32_a :
                   w_zero  ? {is_max ? (fp32_a[31] && fp32_b[31]) : (fp32_a[31] || fp32_b[31]), 31'd0} :
                   w_take_b ? fp32_b : fp32_a;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_fp32_valid <= 1'b0;
            result_valid      <= 1'b0;
            result_fp32       <= 32'd0;
            result            <= 1'b0;
            nan_err           <= 1'b0;
        end else begin
            result_fp32_valid <= in_valid;
            result_valid      <= in_valid;
            if (in_valid) begin
                result_fp32 <= w_pick;
                result      <= w_pred;
                nan_err     <= w_nan;
            end
        end
    end
endmodule

// File: tb/tb_fp32_cmp_unit.sv
// tb_fp32_cmp_unit: directed-vector scoreboard bench for fp32_cmp_unit.
module tb_fp32_cmp_unit;
    logic        clk = 1'b0;
    logic        reset_n, in_valid, int_mode, is_max;
    logic [2:0]  is_op;
    logic [31:0] in_a, in_b, fp32_a, fp32_b, result_fp32;
    logic        result_fp32_valid, result_valid, result, nan_err;

    typedef struct {
        logic        r;
        logic        n;
        logic [31:0] f;
    } exp_t;

    exp_t q[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    fp32_cmp_unit dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .int_mode(int_mode),
        .is_max(is_max), .is_op(is_op), .in_a(in_a), .in_b(in_b),
        .fp32_a(fp32_a), .fp32_b(fp32_b), .result_fp32_valid(result_fp32_valid),
        .result_fp32(result_fp32), .result_valid(result_valid), .result(result),
        .nan_err(nan_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic im,
                         input logic mx, input logic [2:0] op,
                         input logic er, input logic en, input logic [31:0] ef);
        exp_t e;
        in_valid = 1'b1;
        int_mode = im;
        is_max   = mx;
        is_op    = op;
        in_a     = a;
        in_b     = b;
        e.r = er;
        e.n = en;
        e.f = ef;
        q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic im,
                         input logic mx, input logic [2:0] op,
                         input logic er, input logic en, input logic [31:0] ef,
                         input logic [31:0] efa, input logic [31:0] efb);
        @(posedge clk);
        #1;
        drive(a, b, im, mx, op, er, en, ef);
        #1;
        chk("fp32_a", {32'd0, fp32_a}, {32'd0, efa});
        chk("fp32_b", {32'd0, fp32_b}, {32'd0, efb});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        is_op    = 3'($urandom_range(0, 7));
    endtask

    // monitor: pops the scoreboard on every valid result, otherwise checks hold/reset values
    initial begin
        exp_t e;
        exp_t last;
        last.r = 1'b0;
        last.n = 1'b0;
        last.f = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("reset_zero", {28'd0, result_fp32_valid, result_valid, result, nan_err, result_fp32}, 64'd0);
                last.r = 1'b0;
                last.n = 1'b0;
                last.f = 32'd0;
            end else if (result_valid) begin
                chk("valid_pair", {63'd0, result_fp32_valid}, 64'd1);
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", {30'd0, result, nan_err, result_fp32}, {30'd0, e.r, e.n, e.f});
                    last = e;
                end
            end else begin
                chk("hold", {29'd0, result_fp32_valid, result, nan_err, result_fp32}, {29'd0, 1'b0, last.r, last.n, last.f});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b1;
        int_mode = 1'b1;
        is_max   = 1'b1;
        is_op    = 3'd3;
        in_a     = 32'd16;
        in_b     = -32'sd17;
        #1000;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(32'd16, -32'sd17, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 32'h4180_0000);
        #1;
        chk("valid_before_edge", {62'd0, result_valid, result_fp32_valid}, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        chk("valid_rise", {62'd0, result_valid, result_fp32_valid}, 64'd3);
        // integer operands 16 and -17, all predicates, back-to-back
        issue(32'd16, -32'sd17, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 32'h4180_0000, 32'h4180_0000, 32'hC188_0000);
        issue(32'd16, -32'sd17, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 32'hC188_0000, 32'h4180_0000, 32'hC188_0000);
        issue(32'd16, -32'sd17, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 32'hC188_0000, 32'h4180_0000, 32'hC188_0000);
        issue(32'd16, -32'sd17, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 32'h4180_0000, 32'h4180_0000, 32'hC188_0000);
        issue(32'd16, -32'sd17, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 32'h4180_0000, 32'h4180_0000, 32'hC188_0000);
        issue(32'd16, -32'sd17, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 32'h4180_0000, 32'h4180_0000, 32'hC188_0000);
        // conversion rounding and extremes
        issue(32'd16777217, 32'd16777219, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 32'h4B80_0002, 32'h4B80_0000, 32'h4B80_0002);
        issue(32'd0, 32'h8000_0000, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 32'hCF00_0000, 32'h0000_0000, 32'hCF00_0000);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 32'hBF80_0000, 32'h4F00_0000, 32'hBF80_0000);
        idle();
        // NaN handling
        issue(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 32'h3F80_0000, 32'h7FC0_0001, 32'h3F80_0000);
        issue(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h3F80_0000, 32'h7FC0_0001, 32'h3F80_0000);
        issue(32'h3F80_0000, 32'h7FC0_0001, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0001);
        issue(32'h7FC0_0001, 32'hFF80_0001, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1, 32'h7FC0_0000, 32'h7FC0_0001, 32'hFF80_0001);
        issue(32'h7FC0_0001, 32'hFF80_0001, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 32'h7FC0_0000, 32'h7FC0_0001, 32'hFF80_0001);
        idle();
        idle();
        // signed zeros
        issue(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000);
        issue(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000);
        issue(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
        issue(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        // infinities, denormals, negatives
        issue(32'h7F80_0000, 32'h7F7F_FFFF, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 32'h7F80_0000, 32'h7F80_0000, 32'h7F7F_FFFF);
        issue(32'hFF80_0000, 32'h0000_0001, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 32'hFF80_0000, 32'hFF80_0000, 32'h0000_0001);
        issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0001, 32'h0000_0002);
        issue(32'h8000_0001, 32'h0000_0000, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 32'h8000_0001, 32'h8000_0001, 32'h0000_0000);
        issue(32'h8000_0001, 32'h0000_0000, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 32'h0000_0000, 32'h8000_0001, 32'h0000_0000);
        issue(32'hBFC0_0000, 32'hC000_0000, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 32'hBFC0_0000, 32'hBFC0_0000, 32'hC000_0000);
        issue(32'hBFC0_0000, 32'hC000_0000, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 32'hC000_0000, 32'hBFC0_0000, 32'hC000_0000);
        issue(32'h4040_0000, 32'h4040_0000, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'h4040_0000, 32'h4040_0000, 32'h4040_0000);
        // reset asserted mid-stream discards the in-flight result
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000);
        @(posedge clk);
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_clear", {28'd0, result_fp32_valid, result_valid, result, nan_err, result_fp32}, 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();
        issue(32'd5, 32'd5, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 32'h40A0_0000, 32'h40A0_0000, 32'h40A0_0000);
        repeat (3) idle();
        @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
